// File: rtl/pipe_controller_v2.sv
// Control unit for a 5-stage RV32I pipeline: decode in D, E/M/W control registers, branch resolution in E.
// Optional macro CTRL_PERF_EN adds retired-instruction and taken-branch/jump counters.
module pipe_controller_v2 #(
   parameter int unsigned ACW   = 4,
   parameter int unsigned CNT_W = 32
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [6:0]     opD,
   input  logic [2:0]     funct3D,
   input  logic           funct7b5D,
   input  logic           validD,
   output logic [2:0]     immsrcD,
   output logic           illegalD,
   input  logic           stallE,
   input  logic           flushE,
   input  logic           flushM,
   input  logic           zeroE,
   input  logic           ltE,
   input  logic           ltuE,
   output logic [1:0]     pcsrcE,
   output logic [ACW-1:0] alucontrolE,
   output logic           alusrcaE,
   output logic           alusrcbE,
   output logic           resultsrcEb0,
   output logic           memwriteM,
   output logic [2:0]     funct3M,
   output logic           regwriteM,
   output logic           regwriteW,
`ifdef CTRL_PERF_EN
   output logic [CNT_W-1:0] instretW,
   output logic [CNT_W-1:0] brtakenE,
`endif
   output logic [1:0]     resultsrcW
);

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLT  = 4'd5;
   localparam logic [3:0] ALU_SLTU = 4'd6;
   localparam logic [3:0] ALU_SLL  = 4'd7;
   localparam logic [3:0] ALU_SRL  = 4'd8;
   localparam logic [3:0] ALU_SRA  = 4'd9;
   localparam logic [3:0] ALU_PASSB = 4'd10;

   if (ACW < 4) begin : g_acw_check
      $error("ACW must be at least 4");
   end
   if (CNT_W < 1) begin : g_cnt_check
      $error("CNT_W must be at least 1");
   end

   logic       regwrite_d, memwrite_d, branch_d, jump_d, jalr_d;
   logic       alusrca_d, alusrcb_d, legal_d;
   logic [1:0] resultsrc_d;
   logic [3:0] alu_d, alu_f3_d;

   logic       regwriteE, memwriteE, jumpE, jalrE, branchE, validE;
   logic [1:0] resultsrcE, resultsrcM;
   logic [2:0] funct3E;
   logic       taken_e;

   // R/I-type arithmetic selection; funct7b5 picks sub (R only) and sra
   always_comb begin
      alu_f3_d = ALU_ADD;
      case (funct3D)
         3'b000:  alu_f3_d = (funct7b5D && opD == 7'b0110011) ? ALU_SUB : ALU_ADD;
         3'b001:  alu_f3_d = ALU_SLL;
         3'b010:  alu_f3_d = ALU_SLT;
         3'b011:  alu_f3_d = ALU_SLTU;
         3'b100:  alu_f3_d = ALU_XOR;
         3'b101:  alu_f3_d = funct7b5D ? ALU_SRA : ALU_SRL;
         3'b110:  alu_f3_d = ALU_OR;
         default: alu_f3_d = ALU_AND;
      endcase
   end

   always_comb begin
      regwrite_d  = 1'b0;
      memwrite_d  = 1'b0;
      branch_d    = 1'b0;
      jump_d      = 1'b0;
      jalr_d      = 1'b0;
      alusrca_d   = 1'b0;
      alusrcb_d   = 1'b0;
      resultsrc_d = 2'b00;
      immsrcD     = 3'b000;
      alu_d       = ALU_ADD;
      legal_d     = 1'b1;
      case (opD)
         7'b0000011: begin regwrite_d = 1'b1; resultsrc_d = 2'b01; alusrcb_d = 1'b1; end
         7'b0100011: begin memwrite_d = 1'b1; alusrcb_d = 1'b1; immsrcD = 3'b001; end
         7'b0110011: begin regwrite_d = 1'b1; alu_d = alu_f3_d; end
         7'b0010011: begin regwrite_d = 1'b1; alusrcb_d = 1'b1; alu_d = alu_f3_d; end
         7'b1100011: begin branch_d = 1'b1; immsrcD = 3'b010; alu_d = ALU_SUB; end
         7'b1101111: begin regwrite_d = 1'b1; jump_d = 1'b1; resultsrc_d = 2'b10; immsrcD = 3'b011; end
         7'b1100111: begin regwrite_d = 1'b1; jalr_d = 1'b1; resultsrc_d = 2'b10; alusrcb_d = 1'b1; end
         7'b0110111: begin regwrite_d = 1'b1; immsrcD = 3'b100; alu_d = ALU_PASSB; end
         7'b0010111: begin regwrite_d = 1'b1; alusrca_d = 1'b1; alusrcb_d = 1'b1; immsrcD = 3'b100; end
         default:    legal_d = 1'b0;
      endcase
   end

   assign illegalD = validD & ~legal_d;

`ifdef CTRL_PERF_EN
   logic illegalE, validM, illegalM, validW, illegalW;
`endif

   // E register: reset > flushE > stallE > load; bubbles in D never write, branch or jump
   always_ff @(posedge clk) begin
      if (reset || flushE) begin
         regwriteE   <= 1'b0;
         resultsrcE  <= 2'b00;
         memwriteE   <= 1'b0;
         jumpE       <= 1'b0;
         jalrE       <= 1'b0;
         branchE     <= 1'b0;
         alucontrolE <= '0;
         alusrcaE    <= 1'b0;
         alusrcbE    <= 1'b0;
         funct3E     <= 3'b000;
         validE      <= 1'b0;
`ifdef CTRL_PERF_EN
         illegalE    <= 1'b0;
`endif
      end else if (!stallE) begin
         regwriteE   <= regwrite_d & validD;
         resultsrcE  <= resultsrc_d;
         memwriteE   <= memwrite_d & validD;
         jumpE       <= jump_d & validD;
         jalrE       <= jalr_d & validD;
         branchE     <= branch_d & validD;
         alucontrolE <= ACW'(alu_d);
         alusrcaE    <= alusrca_d;
         alusrcbE    <= alusrcb_d;
         funct3E     <= funct3D;
         validE      <= validD;
`ifdef CTRL_PERF_EN
         illegalE    <= illegalD;
`endif
      end
   end

   assign resultsrcEb0 = resultsrcE[0];

   always_comb begin
      taken_e = 1'b0;
      case (funct3E)
         3'b000:  taken_e = zeroE;
         3'b001:  taken_e = ~zeroE;
         3'b100:  taken_e = ltE;
         3'b101:  taken_e = ~ltE;
         3'b110:  taken_e = ltuE;
         3'b111:  taken_e = ~ltuE;
         default: taken_e = 1'b0;
      endcase
   end

   always_comb begin
      pcsrcE = 2'b00;
      if (validE && jalrE)
         pcsrcE = 2'b10;
      else if (validE && (jumpE || (branchE && taken_e)))
         pcsrcE = 2'b01;
   end

   // M register advances even while E is stalled
   always_ff @(posedge clk) begin
      if (reset || flushM) begin
         regwriteM  <= 1'b0;
         resultsrcM <= 2'b00;
         memwriteM  <= 1'b0;
         funct3M    <= 3'b000;
`ifdef CTRL_PERF_EN
         validM     <= 1'b0;
         illegalM   <= 1'b0;
`endif
      end else begin
         regwriteM  <= regwriteE;
         resultsrcM <= resultsrcE;
         memwriteM  <= memwriteE;
         funct3M    <= funct3E;
`ifdef CTRL_PERF_EN
         validM     <= validE;
         illegalM   <= illegalE;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         regwriteW  <= 1'b0;
         resultsrcW <= 2'b00;
`ifdef CTRL_PERF_EN
         validW     <= 1'b0;
         illegalW   <= 1'b0;
`endif
      end else begin
         regwriteW  <= regwriteM;
         resultsrcW <= resultsrcM;
`ifdef CTRL_PERF_EN
         validW     <= validM;
         illegalW   <= illegalM;
`endif
      end
   end

`ifdef CTRL_PERF_EN
   // Free-running wrap-around counters
   always_ff @(posedge clk) begin
      if (reset) begin
         instretW <= '0;
         brtakenE <= '0;
      end else begin
         if (validW && !illegalW)
            instretW <= instretW + CNT_W'(1);
         if (validE && !stallE && pcsrcE != 2'b00)
            brtakenE <= brtakenE + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_pipe_controller_v2.sv
// Randomized self-checking bench for pipe_controller_v2 against a decode-table and pipeline-queue model.
// Counter checks are included when CTRL_PERF_EN is defined.
module tb_pipe_controller_v2;

   localparam int unsigned ACW   = 4;
   localparam int unsigned CNT_W = 4;

   logic           clk = 1'b0;
   logic           reset;
   logic [6:0]     opD;
   logic [2:0]     funct3D;
   logic           funct7b5D, validD, stallE, flushE, flushM, zeroE, ltE, ltuE;
   logic [2:0]     immsrcD;
   logic           illegalD;
   logic [1:0]     pcsrcE;
   logic [ACW-1:0] alucontrolE;
   logic           alusrcaE, alusrcbE, resultsrcEb0, memwriteM, regwriteM, regwriteW;
   logic [2:0]     funct3M;
   logic [1:0]     resultsrcW;
`ifdef CTRL_PERF_EN
   logic [CNT_W-1:0] instretW, brtakenE;
`endif

   pipe_controller_v2 #(.ACW(ACW), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .opD(opD), .funct3D(funct3D), .funct7b5D(funct7b5D),
      .validD(validD), .immsrcD(immsrcD), .illegalD(illegalD), .stallE(stallE),
      .flushE(flushE), .flushM(flushM), .zeroE(zeroE), .ltE(ltE), .ltuE(ltuE),
      .pcsrcE(pcsrcE), .alucontrolE(alucontrolE), .alusrcaE(alusrcaE), .alusrcbE(alusrcbE),
      .resultsrcEb0(resultsrcEb0), .memwriteM(memwriteM), .funct3M(funct3M),
      .regwriteM(regwriteM), .regwriteW(regwriteW),
`ifdef CTRL_PERF_EN
      .instretW(instretW), .brtakenE(brtakenE),
`endif
      .resultsrcW(resultsrcW)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       rw;
      logic [1:0] rs;
      logic       mw, jmp, jr, br;
      logic [3:0] alu;
      logic       sa, sb;
      logic [2:0] f3;
      logic       vld, ill;
   } ctl_t;

   // ALU code by funct3 for the plain (funct7b5=0) arithmetic ops
   localparam logic [3:0] ALU_OF_F3 [8] = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
   localparam logic [6:0] OPS [10] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                                       7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011};

   int   n_err = 0;
   int   n_chk = 0;
   ctl_t e_q, m_q, w_q;
   int   cnt_ir, cnt_bt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_decode(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                        input logic v, output ctl_t c, output logic [2:0] imm);
      c = '0;
      imm = 3'd0;
      c.f3 = f3;
      c.vld = v;
      case (op)
         7'b0000011: begin c.rw = 1; c.rs = 2'd1; c.sb = 1; end
         7'b0100011: begin c.mw = 1; c.sb = 1; imm = 3'd1; end
         7'b0110011: begin
            c.rw = 1; c.alu = ALU_OF_F3[f3];
            if (f7 && f3 == 3'd0) c.alu = 4'd1;
            if (f7 && f3 == 3'd5) c.alu = 4'd9;
         end
         7'b0010011: begin
            c.rw = 1; c.sb = 1; c.alu = ALU_OF_F3[f3];
            if (f7 && f3 == 3'd5) c.alu = 4'd9;
         end
         7'b1100011: begin c.br = 1; imm = 3'd2; c.alu = 4'd1; end
         7'b1101111: begin c.rw = 1; c.jmp = 1; c.rs = 2'd2; imm = 3'd3; end
         7'b1100111: begin c.rw = 1; c.jr = 1; c.rs = 2'd2; c.sb = 1; end
         7'b0110111: begin c.rw = 1; imm = 3'd4; c.alu = 4'd10; end
         7'b0010111: begin c.rw = 1; c.sa = 1; c.sb = 1; imm = 3'd4; end
         default:    c.ill = v;
      endcase
      if (!v) begin
         c.rw = 0; c.mw = 0; c.jmp = 0; c.jr = 0; c.br = 0;
      end
   endfunction

   function automatic logic [1:0] model_pc(input ctl_t e, input logic z, input logic l, input logic lu);
      logic [7:0] cond;
      cond = {~lu, lu, ~l, l, 1'b0, 1'b0, ~z, z};
      if (!e.vld)                      return 2'd0;
      if (e.jr)                        return 2'd2;
      if (e.jmp || (e.br && cond[e.f3])) return 2'd1;
      return 2'd0;
   endfunction

   // One clock: drive at negedge, compare, then advance the model at posedge
   task automatic cycle(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic v,
                        input logic st, input logic fe, input logic fm, input logic z,
                        input logic l, input logic lu, input logic r);
      ctl_t       d;
      logic [2:0] imm;
      logic [1:0] pc;
      @(negedge clk);
      opD = op; funct3D = f3; funct7b5D = f7; validD = v; stallE = st; flushE = fe;
      flushM = fm; zeroE = z; ltE = l; ltuE = lu; reset = r;
      #1;
      model_decode(op, f3, f7, v, d, imm);
      pc = model_pc(e_q, z, l, lu);
      check("immsrcD", 32'(immsrcD), 32'(imm));
      check("illegalD", 32'(illegalD), 32'(d.ill));
      check("pcsrcE", 32'(pcsrcE), 32'(pc));
      check("alucontrolE", 32'(alucontrolE), 32'(e_q.alu));
      check("alusrcaE", 32'(alusrcaE), 32'(e_q.sa));
      check("alusrcbE", 32'(alusrcbE), 32'(e_q.sb));
      check("resultsrcEb0", 32'(resultsrcEb0), 32'(e_q.rs[0]));
      check("memwriteM", 32'(memwriteM), 32'(m_q.mw));
      check("funct3M", 32'(funct3M), 32'(m_q.f3));
      check("regwriteM", 32'(regwriteM), 32'(m_q.rw));
      check("regwriteW", 32'(regwriteW), 32'(w_q.rw));
      check("resultsrcW", 32'(resultsrcW), 32'(w_q.rs));
`ifdef CTRL_PERF_EN
      check("instretW", 32'(instretW), 32'(cnt_ir));
      check("brtakenE", 32'(brtakenE), 32'(cnt_bt));
`endif
      @(posedge clk);
      if (r) begin
         e_q = '0; m_q = '0; w_q = '0; cnt_ir = 0; cnt_bt = 0;
      end else begin
         if (w_q.vld && !w_q.ill) cnt_ir = (cnt_ir + 1) % (1 << CNT_W);
         if (e_q.vld && !st && pc != 2'd0) cnt_bt = (cnt_bt + 1) % (1 << CNT_W);
         w_q = m_q;
         m_q = fm ? '0 : e_q;
         if (fe)       e_q = '0;
         else if (!st) e_q = d;
      end
      #1;
   endtask

   initial begin
      logic [6:0] op;
      e_q = '0; m_q = '0; w_q = '0; cnt_ir = 0; cnt_bt = 0;
      opD = 7'b0110011; funct3D = 0; funct7b5D = 0; validD = 1; stallE = 0; flushE = 0;
      flushM = 0; zeroE = 0; ltE = 0; ltuE = 0; reset = 1;
      repeat (2) @(posedge clk);

      // Reset held with an R-type in D
      cycle(7'b0110011, 3'd0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
      cycle(7'b0110011, 3'd0, 0, 1, 0, 0, 0, 0, 0, 0, 1);
      check("rst_pcsrcE", 32'(pcsrcE), 32'd0);

      // R-type sub through the pipe
      cycle(7'b0110011, 3'd0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
      check("sub_alu", 32'(alucontrolE), 32'd1);
      cycle(7'b0000000, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle(7'b0000000, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("sub_regwriteW", 32'(regwriteW), 32'd1);
      check("sub_resultsrcW", 32'(resultsrcW), 32'd0);

      // bltu held in E while flags vary, then an unused funct3
      cycle(7'b1100011, 3'd6, 0, 1, 0, 0, 0, 0, 0, 1, 0);
      check("bltu_taken", 32'(pcsrcE), 32'd1);
      cycle(7'b0000000, 3'd0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      check("bltu_not", 32'(pcsrcE), 32'd0);
      cycle(7'b1100011, 3'd2, 0, 1, 0, 0, 0, 1, 1, 1, 0);
      check("br_f3_010", 32'(pcsrcE), 32'd0);

      // jalr, then flush with stall together
      cycle(7'b1100111, 3'd0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      check("jalr_pc", 32'(pcsrcE), 32'd2);
      cycle(7'b0110011, 3'd0, 1, 1, 1, 1, 0, 0, 0, 0, 0);
      check("flush_pc", 32'(pcsrcE), 32'd0);
      check("flush_alu", 32'(alucontrolE), 32'd0);
      check("flush_srcb", 32'(alusrcbE), 32'd0);

      // Store stalled in E for three cycles, M flushed on the middle one
      cycle(7'b0100011, 3'd2, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      cycle(7'b0110011, 3'd0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
      check("sw_stall_m", 32'(memwriteM), 32'd1);
      cycle(7'b0110011, 3'd0, 0, 1, 1, 0, 1, 0, 0, 0, 0);
      check("sw_flushm", 32'(memwriteM), 32'd0);
      cycle(7'b0110011, 3'd0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
      check("sw_hold_srcb", 32'(alusrcbE), 32'd1);

      // SYSTEM opcode is illegal and writes nothing
      cycle(7'b1110011, 3'd0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      cycle(7'b0000000, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("ill_regwriteM", 32'(regwriteM), 32'd0);

      // 17 legal instructions, then let them drain
      for (int i = 0; i < 17; i++)
         cycle(7'b0010011, 3'd0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) cycle(7'b0000000, 3'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      for (int i = 0; i < 3000; i++) begin
         op = ($urandom_range(7) == 0) ? 7'($urandom) : OPS[$urandom_range(9)];
         cycle(op, 3'($urandom), 1'($urandom), $urandom_range(9) < 8,
               $urandom_range(4) == 0, $urandom_range(9) == 0, $urandom_range(9) == 0,
               1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(39) == 0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
